alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational 8-bit ALU (sel 4-bit, result 16-bit, zero flag) between two requesters using round-robin arbitration. Each requester issues an opcode and operands through a valid/ready handshake. The block drives the ALU inputs from registered values, holds them for a programmable settle time, and captures result and zero. It returns a tagged response through a second valid/ready handshake. It sits between the ALU instance and the two client blocks.

Parameters:
EXEC_CYCLES, 1, cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_op  in  4  requester 0 opcode (ALU sel encoding)
req0_a  in  8  requester 0 operand A
req0_b  in  8  requester 0 operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester index the response belongs to
rsp_result  out  16  captured ALU result
rsp_zero  out  1  captured ALU zero flag
rsp_err  out  1  illegal opcode, or DIV/MOD with B=0
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_sel  out  4  to ALU sel
alu_result  in  16  from ALU result
alu_zero  in  1  from ALU zero
busy  out  1  high whenever state is not IDLE
op_count  out  16  completed responses (wraps modulo 2^16)

Behaviour:
- Reset: all state and outputs clear asynchronously to 0. State=IDLE; alu_a/alu_b/alu_sel/rsp_* = 0; op_count=0; last_grant=1, so req0 wins the first tie.
- Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR, 8 MUL, 9 DIV, 10 MOD, 11 EQ. Opcodes 12-15 are illegal.
- FSM IDLE:
  - reqN_ready is high only in IDLE and only for the granted requester; at most one ready is high per cycle.
  - Grant: if exactly one valid, grant it. If both valid, grant the index != last_grant.
  - On handshake: register op/a/b into alu_sel/alu_a/alu_b, record id, set last_grant=id, go to EXEC with cnt=EXEC_CYCLES-1.
- Bypass (same handshake edge): an illegal op, or op 9/10 with b==0, goes directly to RESP with rsp_err=1, rsp_result=0, rsp_zero=1. alu_* outputs still load the command.
- FSM EXEC:
  - alu_* outputs are held stable.
  - When cnt==0: capture alu_result/alu_zero into rsp_result/rsp_zero, rsp_err=0, go to RESP. Otherwise decrement cnt.
  - Minimum accept-to-rsp_valid latency is EXEC_CYCLES+1 edges.
- FSM RESP:
  - rsp_valid=1; rsp_id/result/zero/err are held stable until rsp_valid&&rsp_ready.
  - On that edge: op_count++, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake; the next accept is earliest one cycle later.
- Requests not granted stay pending. The requester must hold valid and its payload stable until ready.
- rsp_ready is ignored outside RESP.
- Async reset in any state aborts the operation; the in-flight command is dropped with no response.
- op_count wraps from 16'hFFFF to 0.

Test Plan:
- Single op: req0 op=0 a=10 b=5, rsp_ready=1, EXEC_CYCLES=1. Expect rsp_valid 2 cycles after accept, id=0, result=15, zero=0, err=0, op_count=1.
- Sweep: req1 issues ops 1-11 with a=10 b=5 in sequence. Expect results 5, 0, 15, 15, 245, 20, 5, 50, 2, 0, 0 (NOT A = 8'hF5, zero-extended); zero=1 only for AND, MOD and EQ.
- Contention: both valid continuously, each with a=1 b=1 op=0. Expect grant order id 0, 1, 0, 1; never two readys in one cycle.
- Error bypass:
  - op=9 a=7 b=0 -> rsp_err=1, result=0, zero=1, one cycle after accept.
  - op=13 -> rsp_err=1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP. Expect rsp_* stable, both reqN_ready low, busy=1. Release -> op_count increments once.
- Reset mid-EXEC: EXEC_CYCLES=4, assert rst_n=0 in cycle 2 of EXEC. Expect immediate IDLE, rsp_valid=0, op_count=0, and next tie granted to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external combinational ALU.
// Round-robin grant, registered ALU operands held for EXEC_CYCLES,
// then the captured result is returned on a tagged response handshake.
//
// state | meaning
// IDLE  | waiting for a command; the granted requester sees ready
// EXEC  | ALU inputs held stable while cnt counts down to capture
// RESP  | rsp_valid high; response held until rsp_ready
module alu_arbiter #(
    // Hold time of the ALU inputs before capture; legal range 1..15.
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,

    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,

    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_DIV   = 4'd9;
    localparam logic [3:0] OP_MOD   = 4'd10;
    localparam logic [3:0] OP_LAST  = 4'd11;
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic [3:0]  cnt;

    logic        gnt_vld;
    logic        gnt_id;
    logic        accept;
    logic        cmd_bad;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    // Ready only in IDLE and only toward the granted requester, so at most one is high.
    always_comb begin
        req0_ready = (state == IDLE) && gnt_vld && !gnt_id;
        req1_ready = (state == IDLE) && gnt_vld &&  gnt_id;
        accept     = (state == IDLE) && gnt_vld;
    end

    // Select the granted payload and flag commands that must skip the ALU.
    always_comb begin
        cmd_op = gnt_id ? req1_op : req0_op;
        cmd_a  = gnt_id ? req1_a  : req0_a;
        cmd_b  = gnt_id ? req1_b  : req0_b;
        // Opcodes above EQ are undefined; DIV/MOD by zero would give a meaningless result.
        cmd_bad = (cmd_op > OP_LAST) ||
                  (((cmd_op == OP_DIV) || (cmd_op == OP_MOD)) && (cmd_b == 8'd0));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = cmd_bad ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command registers, settle counter, response capture and completion count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_sel    <= 4'd0;
            rsp_id     <= 1'b0;
            rsp_result <= 16'd0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            op_count   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_sel    <= cmd_op;
                        rsp_id     <= gnt_id;
                        last_grant <= gnt_id;
                        cnt        <= CNT_LOAD;
                        // Bypassed commands get their error response right away.
                        if (cmd_bad) begin
                            rsp_err    <= 1'b1;
                            rsp_result <= 16'd0;
                            rsp_zero   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a fast instance (EXEC_CYCLES=1) for the
// functional sweep and a slow instance (EXEC_CYCLES=4) for latency and reset abort.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Fast instance signals
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [15:0] rsp_result;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        busy;
    logic [15:0] op_count;

    // Slow instance signals
    logic        d4_rst_n;
    logic        d4_req0_valid, d4_req0_ready, d4_req1_valid, d4_req1_ready;
    logic [3:0]  d4_req0_op, d4_req1_op;
    logic [7:0]  d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
    logic        d4_rsp_valid, d4_rsp_ready, d4_rsp_id, d4_rsp_zero, d4_rsp_err;
    logic [15:0] d4_rsp_result;
    logic [7:0]  d4_alu_a, d4_alu_b;
    logic [3:0]  d4_alu_sel;
    logic [15:0] d4_alu_result;
    logic        d4_alu_zero;
    logic        d4_busy;
    logic [15:0] d4_op_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    // Behavioural stand-in for the shared ALU; shifts move by one bit.
    function automatic logic [16:0] alu_model(input logic [3:0] sel, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [15:0] r;
        case (sel)
            4'd0:    r = 16'(a) + 16'(b);
            4'd1:    r = {8'h00, a - b};
            4'd2:    r = {8'h00, a & b};
            4'd3:    r = {8'h00, a | b};
            4'd4:    r = {8'h00, a ^ b};
            4'd5:    r = {8'h00, ~a};
            4'd6:    r = 16'(a) << 1;
            4'd7:    r = 16'(a >> 1);
            4'd8:    r = 16'(a) * 16'(b);
            4'd9:    r = (b != 8'd0) ? 16'(a / b) : 16'hFFFF;
            4'd10:   r = (b != 8'd0) ? 16'(a % b) : 16'hFFFF;
            4'd11:   r = {15'd0, a == b};
            default: r = 16'd0;
        endcase
        return {r == 16'd0, r};
    endfunction

    assign {alu_zero, alu_result}       = alu_model(alu_sel, alu_a, alu_b);
    assign {d4_alu_zero, d4_alu_result} = alu_model(d4_alu_sel, d4_alu_a, d4_alu_b);

    alu_arbiter #(.EXEC_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.EXEC_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(d4_rst_n),
        .req0_valid(d4_req0_valid), .req0_ready(d4_req0_ready), .req0_op(d4_req0_op),
        .req0_a(d4_req0_a), .req0_b(d4_req0_b),
        .req1_valid(d4_req1_valid), .req1_ready(d4_req1_ready), .req1_op(d4_req1_op),
        .req1_a(d4_req1_a), .req1_b(d4_req1_b),
        .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_id(d4_rsp_id),
        .rsp_result(d4_rsp_result), .rsp_zero(d4_rsp_zero), .rsp_err(d4_rsp_err),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_sel(d4_alu_sel),
        .alu_result(d4_alu_result), .alu_zero(d4_alu_zero),
        .busy(d4_busy), .op_count(d4_op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command on the fast instance, wait for its ready, take the accept edge.
    task automatic issue(input logic id, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        int n;
        if (!id) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            step();
            n++;
        end
        chk("accept_timeout", (n < 20), 1);
        chk("two_readys", req0_ready & req1_ready, 0);
        step();
        if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk("alu_a_load", alu_a, a);
        chk("alu_b_load", alu_b, b);
        chk("alu_sel_load", alu_sel, op);
        chk("busy_after_accept", busy, 1);
    endtask

    // Wait for the response (edges counted from the accept edge) and complete it.
    task automatic expect_rsp(input logic id, input logic [15:0] res, input logic zero,
                              input logic err, input int lat);
        int n;
        n = 1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("rsp_latency", n, lat);
        chk("rsp_id", rsp_id, id);
        chk("rsp_result", rsp_result, res);
        chk("rsp_zero", rsp_zero, zero);
        chk("rsp_err", rsp_err, err);
        chk("ready_in_resp", req0_ready | req1_ready, 0);
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk("op_count", op_count, exp_cnt);
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    logic [15:0] sweep_res [1:11] = '{16'd5, 16'd0, 16'd15, 16'd15, 16'd245, 16'd20,
                                      16'd5, 16'd50, 16'd2, 16'd0, 16'd0};
    logic        sweep_zero [1:11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; d4_rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        d4_req0_valid = 1'b0; d4_req0_op = '0; d4_req0_a = '0; d4_req0_b = '0;
        d4_req1_valid = 1'b0; d4_req1_op = '0; d4_req1_a = '0; d4_req1_b = '0;
        d4_rsp_ready = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_readys", req0_ready | req1_ready, 0);
        rst_n = 1'b1; d4_rst_n = 1'b1;
        step();

        // Single ADD on requester 0
        issue(1'b0, 4'd0, 8'd10, 8'd5);
        expect_rsp(1'b0, 16'd15, 1'b0, 1'b0, 2);

        // Opcode sweep on requester 1
        for (int op = 1; op <= 11; op++) begin
            issue(1'b1, 4'(op), 8'd10, 8'd5);
            expect_rsp(1'b1, sweep_res[op], sweep_zero[op], 1'b0, 2);
        end

        // Contention: both valid throughout; last grant was 1, so order is 0,1,0,1
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'd1; req0_b = 8'd1;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 8'd1; req1_b = 8'd1;
        for (int g = 0; g < 4; g++) begin
            #1;
            n = 0;
            while (!(req0_ready | req1_ready) && n < 20) begin
                step();
                n++;
            end
            chk("tie_timeout", (n < 20), 1);
            chk("tie_two_readys", req0_ready & req1_ready, 0);
            chk("tie_grant", req1_ready, g % 2);
            step();
            expect_rsp(1'((g % 2)), 16'd2, 1'b0, 1'b0, 2);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Error bypass
        issue(1'b0, 4'd9, 8'd7, 8'd0);
        expect_rsp(1'b0, 16'd0, 1'b1, 1'b1, 1);
        issue(1'b0, 4'd13, 8'd10, 8'd5);
        expect_rsp(1'b0, 16'd0, 1'b1, 1'b1, 1);
        issue(1'b1, 4'd10, 8'd9, 8'd0);
        expect_rsp(1'b1, 16'd0, 1'b1, 1'b1, 1);

        // Backpressure in RESP
        rsp_ready = 1'b0;
        issue(1'b1, 4'd0, 8'd3, 8'd4);
        n = 1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp_latency", n, 2);
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'd1; req0_b = 8'd1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_result", rsp_result, 16'd7);
            chk("bp_rsp_id", rsp_id, 1);
            chk("bp_readys", req0_ready | req1_ready, 0);
            chk("bp_busy", busy, 1);
            step();
        end
        chk("bp_op_count_hold", op_count, exp_cnt);
        rsp_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk("bp_op_count", op_count, exp_cnt);
        chk("bp_rsp_valid_drop", rsp_valid, 0);
        chk("bp_ready_after", req0_ready, 1);
        req0_valid = 1'b0;
        step();
        chk("bp_op_count_once", op_count, exp_cnt);
        chk("bp_idle", busy, 0);

        // Slow instance: full MUL on requester 1, latency EXEC_CYCLES+1 = 5
        d4_req1_valid = 1'b1; d4_req1_op = 4'd8; d4_req1_a = 8'd6; d4_req1_b = 8'd7;
        #1;
        chk("d4_ready1", d4_req1_ready, 1);
        step();
        d4_req1_valid = 1'b0;
        n = 1;
        while (!d4_rsp_valid && n < 20) begin
            chk("d4_alu_hold", {d4_alu_sel, d4_alu_a, d4_alu_b}, {4'd8, 8'd6, 8'd7});
            step();
            n++;
        end
        chk("d4_latency", n, 5);
        chk("d4_rsp_result", d4_rsp_result, 16'd42);
        chk("d4_rsp_zero", d4_rsp_zero, 0);
        chk("d4_rsp_id", d4_rsp_id, 1);
        step();
        chk("d4_op_count", d4_op_count, 1);

        // Slow instance: abort a requester-0 command in its second EXEC cycle
        d4_req0_valid = 1'b1; d4_req0_op = 4'd0; d4_req0_a = 8'd9; d4_req0_b = 8'd9;
        #1;
        chk("d4_ready0", d4_req0_ready, 1);
        step();
        d4_req0_valid = 1'b0;
        chk("d4_busy_exec", d4_busy, 1);
        step();
        #2;
        d4_rst_n = 1'b0;
        #1;
        chk("abort_busy", d4_busy, 0);
        chk("abort_rsp_valid", d4_rsp_valid, 0);
        chk("abort_op_count", d4_op_count, 0);
        chk("abort_alu_a", d4_alu_a, 0);
        #1;
        d4_rst_n = 1'b1;
        step();
        chk("abort_no_rsp", d4_rsp_valid, 0);
        d4_req0_valid = 1'b1; d4_req1_valid = 1'b1;
        #1;
        chk("abort_tie_req0", d4_req0_ready, 1);
        chk("abort_tie_req1", d4_req1_ready, 0);
        d4_req0_valid = 1'b0; d4_req1_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
